// File: rtl/rom_arbiter.sv
// rom_arbiter
// Two-port round-robin arbiter and read sequencer sharing one combinational
// ROM between two requesters. Each requester issues a read on a valid/ready
// handshake and receives the word on a response channel that is held until
// consumed. Out-of-range addresses are flagged and return zero.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req0_valid/addr/ready    requester 0 read request
//   rsp0_valid/ready/data/err requester 0 response
//   req1_* / rsp1_*          same set for requester 1
//   rom_addr                 registered ROM address
//   rom_data                 combinational ROM output
//   busy                     high whenever a transaction is in flight
module rom_arbiter #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_err,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [31:0] DEPTH_L = 32'(DEPTH);

    logic [1:0]        state;
    logic              grant;
    logic              last_grant;
    logic [DATA_W-1:0] data_q;
    logic              err_q;

    logic              sel;
    logic              hs;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_oob;
    logic              rsp_done;

    // Requester 1 wins when it is alone, or on a tie when requester 0 was
    // served last. Otherwise requester 0 is selected.
    always_comb begin
        sel      = req1_valid && (!req0_valid || !last_grant);
        sel_addr = sel ? req1_addr : req0_addr;
        // Unsigned compare, widened so DEPTH may exceed the address range.
        sel_oob  = ({{(32-ADDR_W){1'b0}}, sel_addr} >= DEPTH_L);
    end

    // Readies are gated by reset so nothing is accepted while it is held.
    assign req0_ready = !rst && (state == IDLE) && req0_valid && !sel;
    assign req1_ready = !rst && (state == IDLE) && sel;
    assign hs         = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign rsp_done   = (state == RESP) && (grant ? rsp1_ready : rsp0_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            rom_addr   <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        grant    <= sel;
                        rom_addr <= sel_addr;
                        err_q    <= sel_oob;
                        state    <= READ;
                    end
                end
                READ: begin
                    // Out-of-range reads never expose ROM contents.
                    data_q <= err_q ? '0 : rom_data;
                    state  <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp0_valid = (state == RESP) && !grant;
    assign rsp1_valid = (state == RESP) && grant;
    assign rsp0_data  = data_q;
    assign rsp1_data  = data_q;
    assign rsp0_err   = err_q;
    assign rsp1_err   = err_q;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_rom_arbiter.sv
module tb_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [5:0]  req0_addr, req1_addr;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_data, rsp1_data;
    logic        rsp0_err, rsp1_err;
    logic [5:0]  rom_addr;
    logic [31:0] rom_data;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // ROM model: mem[i] = A5000000 + i; beyond the array returns a nonzero
    // pattern so a missing out-of-range mask would be visible.
    assign rom_data = (rom_addr < 6'd32) ? (32'hA500_0000 + {26'd0, rom_addr})
                                         : 32'hDEAD_BEEF;

    rom_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .rsp1_err(rsp1_err),
        .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled on the negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_addr = 6'd0;
        req1_valid = 1'b0; req1_addr = 6'd0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_data", rsp0_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b0;

        // Single read, addr 5
        req0_valid = 1'b1; req0_addr = 6'd5; rsp0_ready = 1'b1;
        #1;
        chk("single_req0_ready", 32'(req0_ready), 32'd1);
        chk("single_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        chk("single_T1_busy", 32'(busy), 32'd1);
        chk("single_T1_rom_addr", 32'(rom_addr), 32'd5);
        chk("single_T1_rsp0_valid", 32'(rsp0_valid), 32'd0);
        tick();
        chk("single_T2_rsp0_valid", 32'(rsp0_valid), 32'd1);
        chk("single_T2_data", rsp0_data, 32'hA500_0005);
        chk("single_T2_err", 32'(rsp0_err), 32'd0);
        tick();
        chk("single_T3_busy", 32'(busy), 32'd0);
        chk("single_T3_rsp0_valid", 32'(rsp0_valid), 32'd0);

        // Async reset while a response is pending
        req0_valid = 1'b1; req0_addr = 6'd7; rsp0_ready = 1'b0;
        tick();
        req0_valid = 1'b0;
        tick();
        chk("pre_rst_rsp0_valid", 32'(rsp0_valid), 32'd1);
        chk("pre_rst_data", rsp0_data, 32'hA500_0007);
        #2 rst = 1'b1;
        req0_valid = 1'b1;
        #1;
        chk("mid_rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("mid_rst_data", rsp0_data, 32'd0);
        chk("mid_rst_req0_ready", 32'(req0_ready), 32'd0);
        @(negedge clk);
        chk("held_rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        rst = 1'b0;

        // Round-robin: first tie after reset goes to requester 0
        req0_valid = 1'b1; req0_addr = 6'd1;
        req1_valid = 1'b1; req1_addr = 6'd2;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic g;
            g = 1'(i % 2);
            #1;
            chk($sformatf("rr%0d_req0_ready", i), 32'(req0_ready), 32'(!g));
            chk($sformatf("rr%0d_req1_ready", i), 32'(req1_ready), 32'(g));
            tick();
            tick();
            chk($sformatf("rr%0d_rsp0_valid", i), 32'(rsp0_valid), 32'(!g));
            chk($sformatf("rr%0d_rsp1_valid", i), 32'(rsp1_valid), 32'(g));
            chk($sformatf("rr%0d_data", i), g ? rsp1_data : rsp0_data,
                g ? 32'hA500_0002 : 32'hA500_0001);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Out of range on requester 1, then the last valid entry
        req1_valid = 1'b1; req1_addr = 6'd33;
        #1;
        chk("oob_req1_ready", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("oob_rsp1_valid", 32'(rsp1_valid), 32'd1);
        chk("oob_data", rsp1_data, 32'd0);
        chk("oob_err", 32'(rsp1_err), 32'd1);
        tick();
        req1_valid = 1'b1; req1_addr = 6'd31;
        tick();
        req1_valid = 1'b0;
        tick();
        chk("last_rsp1_valid", 32'(rsp1_valid), 32'd1);
        chk("last_data", rsp1_data, 32'hA500_001F);
        chk("last_err", 32'(rsp1_err), 32'd0);
        tick();

        // Back-pressure: requester 0 stalls its response, requester 1 waits
        req0_valid = 1'b1; req0_addr = 6'd3; rsp0_ready = 1'b0;
        req1_valid = 1'b1; req1_addr = 6'd4;
        #1;
        chk("bp_req0_ready", 32'(req0_ready), 32'd1);
        chk("bp_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp%0d_rsp0_valid", i), 32'(rsp0_valid), 32'd1);
            chk($sformatf("bp%0d_data", i), rsp0_data, 32'hA500_0003);
            chk($sformatf("bp%0d_req1_ready", i), 32'(req1_ready), 32'd0);
            tick();
        end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        #1;
        chk("bp_after_req1_ready", 32'(req1_ready), 32'd1);
        chk("bp_after_req0_ready", 32'(req0_ready), 32'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("bp_rsp1_valid", 32'(rsp1_valid), 32'd1);
        chk("bp_rsp1_data", rsp1_data, 32'hA500_0004);
        chk("bp_rsp0_valid", 32'(rsp0_valid), 32'd0);
        tick();

        // Idle stability
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("idle%0d_busy", i), 32'(busy), 32'd0);
            chk($sformatf("idle%0d_readies", i), 32'({req0_ready, req1_ready}), 32'd0);
            chk($sformatf("idle%0d_valids", i), 32'({rsp0_valid, rsp1_valid}), 32'd0);
            chk($sformatf("idle%0d_rom_addr", i), 32'(rom_addr), 32'd4);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
